bram_req_bridge: RTL and testbench
==================================

Name: bram_req_bridge

Overview:
- Upstream front-end for the 4096x32 byte-writable block RAM. Converts a valid/ready request/response channel into the RAM's single-port strobe interface: byte address, EN, 4-bit WE, DI, with DO returned one cycle after a read enable.
- Handles one outstanding transaction, address-window decode with error response, zero-strobe writes, and response backpressure.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the RAM window; must be aligned to the window size.
- DEPTH_WORDS, 4096: RAM depth in 32-bit words; window size is DEPTH_WORDS*4 bytes.
- ADDR_WIDTH, 32: request and RAM address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  bridge can accept a request.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- REQ_WSTRB  in  4  byte enables for writes; ignored for reads.
- REQ_WDATA  in  32  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer takes the response.
- RSP_RDATA  out  32  read data; 0 for writes and errors.
- RSP_ERR  out  1  address outside the window.
- BRAM_A  out  ADDR_WIDTH  byte address to the RAM; bits [1:0] always 0; offset from BASE_ADDR.
- BRAM_EN  out  1  RAM enable.
- BRAM_WE  out  4  RAM byte write enables.
- BRAM_DI  out  32  RAM write data.
- BRAM_DO  in  32  RAM read data, valid the cycle after a read enable.

Behaviour:
- Reset (RST low, async): state=IDLE; REQ_READY=0 while RST is low; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0; BRAM_EN=0, BRAM_WE=0, BRAM_A=0, BRAM_DI=0.
- BRAM_* outputs are registered.
- IDLE: REQ_READY=1. On accept (REQ_VALID & REQ_READY), the request is decoded:
  - Hit = BASE_ADDR <= REQ_ADDR < BASE_ADDR + DEPTH_WORDS*4.
  - Miss: no RAM access; go to RESP with RSP_ERR=1 and RSP_RDATA=0.
  - Hit read: next cycle BRAM_EN=1, BRAM_WE=0, BRAM_A={offset[ADDR_WIDTH-1:2],2'b00}; go to ISSUE.
  - Hit write, REQ_WSTRB!=0: next cycle BRAM_EN=1, BRAM_WE=REQ_WSTRB, BRAM_DI=REQ_WDATA; go to ISSUE.
  - Hit write, REQ_WSTRB==0: no RAM access, because WE=0 with EN=1 would be treated by the RAM as a read. Go to RESP with RSP_ERR=0.
- ISSUE (1 cycle): RAM strobe is active for exactly this cycle. REQ_READY=0. Go to CAPT for reads, RESP for writes. BRAM_EN and BRAM_WE return to 0 on the next edge.
- CAPT (1 cycle, reads only): RSP_RDATA <= BRAM_DO; go to RESP.
- RESP: RSP_VALID=1; RSP_RDATA and RSP_ERR stay stable until RSP_READY=1. On handshake: RSP_VALID=0 on the next edge, state=IDLE.
- Latency from accept edge to RSP_VALID high: read 3 cycles, RAM write 2 cycles, miss or zero-strobe write 1 cycle.
- Throughput: at most one transaction in flight; REQ_READY=0 in every state other than IDLE.
- RSP_RDATA capture uses BRAM_DO only in CAPT; later changes on BRAM_DO are ignored.
- Address wrap: an offset computed past the window cannot occur because of the hit check. The top of the window (offset DEPTH_WORDS*4-4) is a hit.
- Reset mid-transaction: all state clears immediately, and an in-flight RAM strobe is dropped. A write in ISSUE may or may not have committed; this is a documented hazard, not a defect.
- No illegal state: any undefined state encoding returns to IDLE.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, ISSUE, CAPT, RESP (2-bit).
  - Constants: WORD_BYTES=4, STRB_WIDTH=4, DATA_WIDTH=32.
  - Hit-test helper function.
- No sub-module is needed; a single FSM plus registers suffices. The window decoder may be split out as bram_win_decode if it is reused by sibling bridges.

Test Plan:
- Write then read: write 32'hDEADBEEF to BASE+0x10 with WSTRB=4'hF, then read BASE+0x10. Write response comes 2 cycles after accept with ERR=0. Read returns RDATA=DEADBEEF 3 cycles after accept. BRAM_EN is high for exactly 1 cycle per access.
- Partial strobe: preload BASE+0x20 with 32'h11223344, write 32'hAABBCCDD with WSTRB=4'b0101, then read. Required RDATA=32'h11BB33DD.
- Window edges: read BASE+0x3FFC returns data with ERR=0. Read BASE+0x4000 and BASE-4 each return ERR=1, RDATA=0, 1 cycle after accept, with BRAM_EN never asserted.
- Zero strobe: write with WSTRB=0 produces an ack with ERR=0, BRAM_EN stays 0, and a later read of that address is unchanged.
- Backpressure: hold RSP_READY=0 for 10 cycles after a read. RSP_VALID and RSP_RDATA stay stable, REQ_READY=0 throughout, and a second REQ_VALID is not accepted until 1 cycle after the handshake.
- Async reset: drive RST low mid-CAPT, between clock edges. All outputs go to their reset values without a clock edge; after release, REQ_READY=1 on the first edge with RST high.

Source files
------------

// File: rtl/bram_req_bridge_pkg.sv
// bram_req_bridge_pkg: shared state encoding, widths and window hit test for the RAM request bridges.
package bram_req_bridge_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    localparam int WORD_BYTES = 4;
    localparam int STRB_WIDTH = 4;
    localparam int DATA_WIDTH = 32;

    // Widened to 64 bits so base + window size cannot wrap for a window at the top of memory.
    function automatic logic win_hit(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] words);
        return addr >= base && addr < base + words * 64'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/bram_req_bridge.sv
// bram_req_bridge: valid/ready request channel to single-port byte-writable block RAM strobes.
module bram_req_bridge
    import bram_req_bridge_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
    parameter int unsigned             DEPTH_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] bram_a,
    output logic                  bram_en,
    output logic [STRB_WIDTH-1:0] bram_we,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    state_t state, state_nxt;
    logic alive;
    logic accept, hit, zero_wr, access;
    logic [ADDR_WIDTH-1:0] offset;

    assign accept  = req_valid && req_ready;
    assign hit     = win_hit(64'(req_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    // A zero-strobe write must not reach the RAM: EN with WE=0 is a read there.
    assign zero_wr = req_write && req_wstrb == '0;
    assign access  = accept && hit && !zero_wr;
    assign offset  = req_addr - BASE_ADDR;

    // alive holds ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = !accept ? IDLE : access ? ISSUE : RESP;
            ISSUE:   state_nxt = bram_we == '0 ? CAPT : RESP;
            CAPT:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = alive && state == IDLE;
        rsp_valid = state == RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_a    <= '0;
            bram_di   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            bram_en <= access;
            bram_we <= access && req_write ? req_wstrb : '0;
            if (access) bram_a <= {offset[ADDR_WIDTH-1:2], 2'b00};
            if (access && req_write) bram_di <= req_wdata;
            if (accept) begin
                rsp_err   <= !hit;
                rsp_rdata <= '0;
            end else if (state == CAPT) begin
                rsp_rdata <= bram_do;
            end
        end
    end

endmodule

// File: tb/tb_bram_req_bridge.sv
// tb_bram_req_bridge: directed checks of the bridge against a behavioural 4096x32 byte-writable RAM.
module tb_bram_req_bridge;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata, bram_a, bram_di, bram_do;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] mem [4096];
    int          en_cycles = 0;
    int          checks = 0, passes = 0;

    bram_req_bridge #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bram_a(bram_a), .bram_en(bram_en), .bram_we(bram_we), .bram_di(bram_di), .bram_do(bram_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) begin
            en_cycles <= en_cycles + 1;
            if (bram_we == 4'b0000) bram_do <= mem[bram_a[13:2]];
            else for (int b = 0; b < 4; b++) if (bram_we[b]) mem[bram_a[13:2]][8*b +: 8] <= bram_di[8*b +: 8];
        end
    end

    task automatic do_req(input logic w, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                          output int lat, output logic [31:0] rdata, output logic err, output int ens);
        int e0;
        @(negedge clk);
        e0 = en_cycles;
        req_valid = 1'b1; req_write = w; req_addr = addr; req_wstrb = strb; req_wdata = data; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err = rsp_err;
        @(negedge clk);
        ens = en_cycles - e0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, bram_en, bram_we} !== 8'h00 || rsp_rdata !== 32'h0 || bram_a !== 32'h0 || bram_di !== 32'h0)
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b en=%b we=%h rdata=%h a=%h di=%h, expected all 0",
                     req_ready, rsp_valid, rsp_err, bram_en, bram_we, rsp_rdata, bram_a, bram_di);
        else passes++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        else passes++;
    endtask

    task automatic test_write_read();
        int lat, ens;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, err, ens);
        checks++;
        if (lat !== 2 || err !== 1'b0 || ens !== 1) $display("FAIL wr_resp: lat=%0d err=%b en=%0d expected lat=2 err=0 en=1", lat, err, ens);
        else passes++;
        do_req(1'b0, BASE + 32'h10, 4'h0, 32'h0, lat, rd, err, ens);
        checks++;
        if (lat !== 3 || err !== 1'b0 || ens !== 1) $display("FAIL rd_resp: lat=%0d err=%b en=%0d expected lat=3 err=0 en=1", lat, err, ens);
        else passes++;
        checks++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", rd);
        else passes++;
    endtask

    task automatic test_partial_strobe();
        int lat, ens;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, BASE + 32'h20, 4'hF, 32'h11223344, lat, rd, err, ens);
        do_req(1'b1, BASE + 32'h22, 4'b0101, 32'hAABBCCDD, lat, rd, err, ens);
        checks++;
        if (lat !== 2 || ens !== 1) $display("FAIL partial_wr: lat=%0d en=%0d expected lat=2 en=1", lat, ens);
        else passes++;
        do_req(1'b0, BASE + 32'h20, 4'h0, 32'h0, lat, rd, err, ens);
        checks++;
        if (rd !== 32'h11BB33DD || err !== 1'b0) $display("FAIL partial_rd: got %h err=%b expected 11bb33dd err=0", rd, err);
        else passes++;
    endtask

    task automatic test_window_edges();
        int lat, ens;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, BASE + 32'h3FFC, 4'hF, 32'hCAFEF00D, lat, rd, err, ens);
        do_req(1'b0, BASE + 32'h3FFC, 4'h0, 32'h0, lat, rd, err, ens);
        checks++;
        if (rd !== 32'hCAFEF00D || err !== 1'b0 || lat !== 3) $display("FAIL win_top: got %h err=%b lat=%0d expected cafef00d err=0 lat=3", rd, err, lat);
        else passes++;
        do_req(1'b0, BASE + 32'h4000, 4'h0, 32'h0, lat, rd, err, ens);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1 || lat !== 1 || ens !== 0) $display("FAIL win_above: rdata=%h err=%b lat=%0d en=%0d expected 0 1 1 0", rd, err, lat, ens);
        else passes++;
        do_req(1'b0, BASE - 32'h4, 4'h0, 32'h0, lat, rd, err, ens);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1 || lat !== 1 || ens !== 0) $display("FAIL win_below: rdata=%h err=%b lat=%0d en=%0d expected 0 1 1 0", rd, err, lat, ens);
        else passes++;
        do_req(1'b1, BASE + 32'h4000, 4'hF, 32'h55555555, lat, rd, err, ens);
        checks++;
        if (err !== 1'b1 || lat !== 1 || ens !== 0) $display("FAIL win_wr_miss: err=%b lat=%0d en=%0d expected 1 1 0", err, lat, ens);
        else passes++;
    endtask

    task automatic test_zero_strobe();
        int lat, ens;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, BASE + 32'h10, 4'h0, 32'h12345678, lat, rd, err, ens);
        checks++;
        if (err !== 1'b0 || lat !== 1 || ens !== 0) $display("FAIL zero_strb_ack: err=%b lat=%0d en=%0d expected 0 1 0", err, lat, ens);
        else passes++;
        do_req(1'b0, BASE + 32'h10, 4'h0, 32'h0, lat, rd, err, ens);
        checks++;
        if (rd !== 32'hDEADBEEF) $display("FAIL zero_strb_data: got %h expected deadbeef", rd);
        else passes++;
    endtask

    task automatic test_backpressure();
        int n, e0, lat;
        @(negedge clk);
        e0 = en_cycles;
        req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 32'h20; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = BASE + 32'h10;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB33DD || req_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b expected 1 11bb33dd 0", i, rsp_valid, rsp_rdata, req_ready);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (en_cycles - e0 !== 1) $display("FAIL bp_no_accept: en cycles=%0d expected 1", en_cycles - e0);
        else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        else passes++;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3 || rsp_rdata !== 32'hDEADBEEF) $display("FAIL bp_second: lat=%0d rdata=%h expected 3 deadbeef", lat, rsp_rdata);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 32'h10; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, bram_en, bram_we} !== 8'h00 || rsp_rdata !== 32'h0 || bram_a !== 32'h0 || bram_di !== 32'h0)
            $display("FAIL async_reset: ready=%b valid=%b err=%b en=%b we=%h rdata=%h a=%h di=%h, expected all 0",
                     req_ready, rsp_valid, rsp_err, bram_en, bram_we, rsp_rdata, bram_a, bram_di);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL async_release: ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_window_edges();
        test_zero_strobe();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
